// File: rtl/qif_spike_monitor_if.sv
// Result record port of the QIF spike monitor: one windowed measurement per
// valid/ready transfer.
interface qif_spike_monitor_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ISI_W = 12
);
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_count;
    logic [ISI_W-1:0] res_isi_min;
    logic [7:0]       res_vpeak;

    modport master (
        output res_valid, res_count, res_isi_min, res_vpeak,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_count, res_isi_min, res_vpeak,
        output res_ready
    );
endinterface

// File: rtl/qif_spike_monitor.sv
// Windowed observer for the QIF neuron: per fixed-length window it measures the
// spike count, the minimum inter-spike interval and the peak membrane voltage.
module qif_spike_monitor #(
    parameter int unsigned WIN_W = 16,
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ISI_W = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [WIN_W-1:0]           win_len,
    input  logic                       spike_in,
    input  logic [7:0]                 v_in,
    qif_spike_monitor_if.master        res,
    output logic                       ovf,
    output logic                       busy
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIN_W-1:0] k_q, k_d, len_q, len_d, len_eff;
    logic             spike_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_cur;
    logic [7:0]       vpeak_q, vpeak_d, vpeak_cur;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d, isi_min_q, isi_min_d, isi_min_cur;
    logic             have_q, have_d, have_cur;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] res_count_q;
    logic [ISI_W-1:0] res_isi_min_q;
    logic [7:0]       res_vpeak_q;
    logic             ovf_q, ovf_d;
    logic             spk_edge, first, last, sample, win_done, load;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (en)  state_d = StRun;
            StRun:   if (!en) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        spk_edge = spike_in & ~spike_prev_q;
        sample   = (state_q == StRun) && en;
        first    = (k_q == '0);
        // Window length is taken live on k=0 and held from then on.
        len_eff  = len_q;
        if (first) len_eff = (win_len == '0) ? WIN_W'(1) : win_len;
        last     = (k_q == len_eff - WIN_W'(1));
        win_done = sample && last;

        // k=0 folds in fresh accumulators so windows run back-to-back.
        cnt_cur     = first ? '0   : cnt_q;
        vpeak_cur   = first ? 8'h0 : vpeak_q;
        isi_min_cur = first ? '1   : isi_min_q;
        have_cur    = first ? 1'b0 : have_q;

        cnt_d = cnt_cur;
        if (spk_edge && (cnt_cur != '1)) cnt_d = cnt_cur + CNT_W'(1);
        vpeak_d = (v_in > vpeak_cur) ? v_in : vpeak_cur;

        if (spk_edge)                isi_cnt_d = ISI_W'(1);
        else if (isi_cnt_q != '1)    isi_cnt_d = isi_cnt_q + ISI_W'(1);
        else                         isi_cnt_d = isi_cnt_q;

        isi_min_d = isi_min_cur;
        if (spk_edge && have_cur && (isi_cnt_q < isi_min_cur)) isi_min_d = isi_cnt_q;
        have_d = have_cur | spk_edge;

        k_d = '0;
        if (sample && !last) k_d = k_q + WIN_W'(1);
        len_d = sample ? len_eff : len_q;

        load        = win_done && (!res_valid_q || res.res_ready);
        res_valid_d = res_valid_q;
        if (load)                             res_valid_d = 1'b1;
        else if (res_valid_q && res.res_ready) res_valid_d = 1'b0;
        ovf_d = ovf_q | (win_done && res_valid_q && !res.res_ready);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q       <= StIdle;
            k_q           <= '0;
            len_q         <= '0;
            spike_prev_q  <= 1'b0;
            cnt_q         <= '0;
            vpeak_q       <= '0;
            isi_cnt_q     <= '0;
            isi_min_q     <= '0;
            have_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_count_q   <= '0;
            res_isi_min_q <= '0;
            res_vpeak_q   <= '0;
            ovf_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            len_q        <= len_d;
            spike_prev_q <= spike_in;
            if (sample) begin
                cnt_q     <= cnt_d;
                vpeak_q   <= vpeak_d;
                isi_cnt_q <= isi_cnt_d;
                isi_min_q <= isi_min_d;
                have_q    <= have_d;
            end
            res_valid_q <= res_valid_d;
            if (load) begin
                res_count_q   <= cnt_d;
                res_isi_min_q <= isi_min_d;
                res_vpeak_q   <= vpeak_d;
            end
            ovf_q <= ovf_d;
        end
    end

    assign res.res_valid   = res_valid_q;
    assign res.res_count   = res_count_q;
    assign res.res_isi_min = res_isi_min_q;
    assign res.res_vpeak   = res_vpeak_q;
    assign ovf             = ovf_q;
    assign busy            = (state_q == StRun);
endmodule
